// File: rtl/debug_slave_pkg.sv
// Shared types and sizing helpers for the system-clock side of the Nios debug slave.
// cmd_t describes one queued command at the default widths; the top module builds a
// parameter-width equivalent from the same fields.
package debug_slave_pkg;

    localparam int unsigned SR_W_DEF  = 38;
    localparam int unsigned IR_W_DEF  = 2;
    localparam int unsigned DEPTH_DEF = 4;

    typedef struct packed {
        logic [IR_W_DEF-1:0] ir;
        logic [SR_W_DEF-1:0] data;
    } cmd_t;

    // Level counter must represent 0..depth inclusive.
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/nios_debug_slave_sysclk_mc_if.sv
// Command dispatch interface between the debug slave and its OCI consumer.
//   cmd_ready      consumer -> slave  consumer may accept the next command
//   jdo            slave -> consumer  data of last dispatched command
//   cmd_ir         slave -> consumer  IR of last dispatched command
//   take_action    slave -> consumer  one-hot 1-clk pulse, command bit set
//   take_no_action slave -> consumer  one-hot 1-clk pulse, command bit clear
interface nios_debug_slave_sysclk_mc_if #(
    parameter int unsigned SR_W = 38,
    parameter int unsigned IR_W = 2
);
    localparam int unsigned NCH = 2 ** IR_W;

    logic            cmd_ready;
    logic [SR_W-1:0] jdo;
    logic [IR_W-1:0] cmd_ir;
    logic [NCH-1:0]  take_action;
    logic [NCH-1:0]  take_no_action;

    modport master (
        input  cmd_ready,
        output jdo,
        output cmd_ir,
        output take_action,
        output take_no_action
    );

    modport slave (
        output cmd_ready,
        input  jdo,
        input  cmd_ir,
        input  take_action,
        input  take_no_action
    );

endinterface

// File: rtl/dbg_sync_edge.sv
// Synchronises an asynchronous level into clk and emits a 1-clk pulse on its rising edge.
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   async_in level from another clock domain
//   pulse    one-cycle pulse per low-to-high transition seen after synchronisation
module dbg_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // A held level gives one pulse; re-arming needs a low sample in prev_q.
    assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/nios_debug_slave_sysclk_mc.sv
// System-clock side of the Nios debug slave. Synchronises update-IR/update-DR strobes,
// latches the IR, queues each captured shift-register word and dispatches commands
// under a ready handshake as jdo plus one-hot take_action/take_no_action pulses.
//   clk, reset_n   system clock, asynchronous active-low reset
//   ir_in, sr      TCK-domain IR and shift register (stable around their strobes)
//   vs_uir, vs_udr TCK-domain update strobes
//   ovf_clr        clear sticky overflow
//   cmd_if         dispatch interface (cmd_ready in; jdo, cmd_ir, pulses out)
//   fifo_level     occupied command entries
//   overflow       sticky: a command was dropped on a full queue
module nios_debug_slave_sysclk_mc
    import debug_slave_pkg::*;
#(
    parameter int unsigned SR_W        = 38,
    parameter int unsigned IR_W        = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ACTION_BIT  = 36
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [IR_W-1:0]             ir_in,
    input  logic [SR_W-1:0]             sr,
    input  logic                        vs_uir,
    input  logic                        vs_udr,
    input  logic                        ovf_clr,
    nios_debug_slave_sysclk_mc_if.master cmd_if,
    output logic [level_w(DEPTH)-1:0]   fifo_level,
    output logic                        overflow
);

    localparam int unsigned NCH   = 2 ** IR_W;
    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned LVL_W = level_w(DEPTH);

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] data;
    } cmd_entry_t;

    logic uir_pulse;
    logic udr_pulse;

    dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
        .clk     (clk),
        .reset_n (reset_n),
        .async_in(vs_uir),
        .pulse   (uir_pulse)
    );

    dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
        .clk     (clk),
        .reset_n (reset_n),
        .async_in(vs_udr),
        .pulse   (udr_pulse)
    );

    cmd_entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [IR_W-1:0]        ir_q;
    logic                   ovf_q;
    logic [SR_W-1:0]        jdo_q;
    logic [IR_W-1:0]        cmd_ir_q;
    logic [NCH-1:0]         act_q, no_act_q;

    logic                   empty, full, pop, push, drop;
    cmd_entry_t             head;
    logic [NCH-1:0]         head_onehot;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_W'(DEPTH));
    assign pop   = !empty && cmd_if.cmd_ready;
    // A simultaneous pop frees the slot, so a full queue still accepts the push.
    assign push  = udr_pulse && (!full || pop);
    assign drop  = udr_pulse && full && !pop;

    assign head        = mem_q[rd_ptr_q];
    assign head_onehot = NCH'(1) << head.ir;

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ir_q     <= '0;
            ovf_q    <= 1'b0;
        end else begin
            // Pushed entry uses the IR held before any same-cycle update-IR.
            if (push) begin
                mem_q[wr_ptr_q] <= {ir_q, sr};
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (uir_pulse) begin
                ir_q <= ir_in;
            end
            level_q <= level_d;
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jdo_q    <= '0;
            cmd_ir_q <= '0;
            act_q    <= '0;
            no_act_q <= '0;
        end else if (pop) begin
            jdo_q    <= head.data;
            cmd_ir_q <= head.ir;
            if (head.data[ACTION_BIT]) begin
                act_q    <= head_onehot;
                no_act_q <= '0;
            end else begin
                act_q    <= '0;
                no_act_q <= head_onehot;
            end
        end else begin
            act_q    <= '0;
            no_act_q <= '0;
        end
    end

    assign cmd_if.jdo            = jdo_q;
    assign cmd_if.cmd_ir         = cmd_ir_q;
    assign cmd_if.take_action    = act_q;
    assign cmd_if.take_no_action = no_act_q;
    assign fifo_level            = level_q;
    assign overflow              = ovf_q;

endmodule

// File: tb/tb_nios_debug_slave_sysclk_mc.sv
// Directed testbench with a scoreboard of expected dispatched commands.
module tb_nios_debug_slave_sysclk_mc;

    localparam int unsigned SR_W  = 38;
    localparam int unsigned IR_W  = 2;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ABIT  = 36;

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [IR_W-1:0] ir_in;
    logic [SR_W-1:0] sr;
    logic            vs_uir, vs_udr, ovf_clr;
    logic [2:0]      fifo_level;
    logic            overflow;

    nios_debug_slave_sysclk_mc_if #(.SR_W(SR_W), .IR_W(IR_W)) cmd_if ();

    nios_debug_slave_sysclk_mc #(
        .SR_W       (SR_W),
        .IR_W       (IR_W),
        .SYNC_STAGES(SYNC),
        .DEPTH      (DEPTH),
        .ACTION_BIT (ABIT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ir_in     (ir_in),
        .sr        (sr),
        .vs_uir    (vs_uir),
        .vs_udr    (vs_udr),
        .ovf_clr   (ovf_clr),
        .cmd_if    (cmd_if),
        .fifo_level(fifo_level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int              tests = 0;
    int              fails = 0;
    int              pulse_cnt = 0;
    exp_t            exp_q[$];
    logic [IR_W-1:0] model_ir = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every dispatch pulse must match the oldest expected command.
    always @(negedge clk) begin
        exp_t     e;
        logic [3:0] vec;
        if (cmd_if.take_action !== 4'b0 || cmd_if.take_no_action !== 4'b0) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 64'd1, 64'd0);
            end else begin
                e   = exp_q.pop_front();
                vec = 4'b0001 << e.ir;
                chk("jdo", 64'(cmd_if.jdo), 64'(e.data));
                chk("cmd_ir", 64'(cmd_if.cmd_ir), 64'(e.ir));
                chk("take_action", 64'(cmd_if.take_action), e.data[ABIT] ? 64'(vec) : 64'd0);
                chk("take_no_action", 64'(cmd_if.take_no_action),
                    e.data[ABIT] ? 64'd0 : 64'(vec));
            end
        end
    end

    task automatic do_uir(input logic [IR_W-1:0] ir);
        @(negedge clk);
        ir_in  = ir;
        vs_uir = 1'b1;
        repeat (2) @(negedge clk);
        vs_uir = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
        model_ir = ir;
    endtask

    task automatic do_udr(input logic [SR_W-1:0] data, input int hold, input bit expect_push);
        @(negedge clk);
        sr     = data;
        vs_udr = 1'b1;
        if (expect_push) exp_q.push_back({model_ir, data});
        repeat (hold) @(negedge clk);
        vs_udr = 1'b0;
        repeat (SYNC + 3) @(negedge clk);
    endtask

    // Strobe vs_udr and raise cmd_ready (sel=0) or ovf_clr (sel=1) exactly in the
    // cycle where the synchronised update pulse is present.
    task automatic udr_aligned(input logic [SR_W-1:0] data, input bit sel, input bit expect_push);
        @(negedge clk);
        sr     = data;
        vs_udr = 1'b1;
        if (expect_push) exp_q.push_back({model_ir, data});
        @(posedge clk);
        repeat (SYNC - 1) @(posedge clk);
        @(negedge clk);
        if (sel) ovf_clr = 1'b1;
        else cmd_if.cmd_ready = 1'b1;
        @(negedge clk);
        ovf_clr          = 1'b0;
        cmd_if.cmd_ready = 1'b0;
        vs_udr           = 1'b0;
        repeat (SYNC + 3) @(negedge clk);
    endtask

    initial begin
        int base;
        reset_n          = 1'b0;
        ir_in            = '0;
        sr               = '0;
        vs_uir           = 1'b0;
        vs_udr           = 1'b0;
        ovf_clr          = 1'b0;
        cmd_if.cmd_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_jdo", 64'(cmd_if.jdo), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_pulses", 64'({cmd_if.take_action, cmd_if.take_no_action}), 64'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_cmd_ir", 64'(cmd_if.cmd_ir), 64'd0);

        // Single action command with latency check
        do_uir(2'd2);
        @(negedge clk);
        sr     = 38'h30_1234_5678;
        vs_udr = 1'b1;
        exp_q.push_back({model_ir, sr});
        @(posedge clk);
        for (int i = 0; i <= int'(SYNC) + 1; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("lat_act_%0d", i), 64'(cmd_if.take_action),
                (i == int'(SYNC) + 1) ? 64'h4 : 64'h0);
        end
        @(negedge clk);
        #1;
        chk("act_one_clk", 64'(cmd_if.take_action), 64'd0);
        chk("act_jdo_hold", 64'(cmd_if.jdo), 64'h30_1234_5678);
        vs_udr = 1'b0;
        repeat (SYNC + 3) @(negedge clk);

        // No-action command
        do_uir(2'd1);
        base = pulse_cnt;
        do_udr(38'h01_0000_00AB, 2, 1'b1);
        #2;
        chk("noact_cnt", 64'(pulse_cnt), 64'(base + 1));
        chk("noact_cmd_ir", 64'(cmd_if.cmd_ir), 64'd1);

        // Backpressure and overflow
        do_uir(2'd3);
        cmd_if.cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_udr(38'h10_0000_0000 | 38'(i + 1) | (38'(i & 1) << ABIT), 2, i < 4);
        end
        chk("bp_level", 64'(fifo_level), 64'd4);
        chk("bp_ovf", 64'(overflow), 64'd1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        #1;
        chk("ovf_clr", 64'(overflow), 64'd0);
        base = pulse_cnt;
        cmd_if.cmd_ready = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        chk("bp_drain_cnt", 64'(pulse_cnt), 64'(base + 4));
        chk("bp_drain_level", 64'(fifo_level), 64'd0);

        // Full queue: push and pop in the same cycle, then drop with ovf_clr
        cmd_if.cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_udr(38'h20_0000_0100 + 38'(i), 2, 1'b1);
        end
        chk("full_level", 64'(fifo_level), 64'd4);
        udr_aligned(38'h3F_0000_0055, 1'b0, 1'b1);
        chk("pushpop_level", 64'(fifo_level), 64'd4);
        chk("pushpop_ovf", 64'(overflow), 64'd0);
        udr_aligned(38'h00_DEAD_BEEF, 1'b1, 1'b0);
        chk("ovf_set_wins", 64'(overflow), 64'd1);
        chk("drop_level", 64'(fifo_level), 64'd4);
        cmd_if.cmd_ready = 1'b1;
        repeat (6) @(negedge clk);
        #2;
        chk("full_drain_level", 64'(fifo_level), 64'd0);
        chk("full_drain_q", 64'(exp_q.size()), 64'd0);

        // Long strobe yields one push
        base = pulse_cnt;
        do_udr(38'h10_5555_AAAA, 20, 1'b1);
        #2;
        chk("long_strobe_cnt", 64'(pulse_cnt), 64'(base + 1));

        // Simultaneous update-IR and update-DR: command carries the old IR
        @(negedge clk);
        ir_in  = 2'd0;
        sr     = 38'h00_0000_0C0C;
        vs_uir = 1'b1;
        vs_udr = 1'b1;
        exp_q.push_back({model_ir, sr});
        repeat (2) @(negedge clk);
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        model_ir = 2'd0;
        repeat (SYNC + 3) @(negedge clk);
        chk("same_cycle_old_ir", 64'(cmd_if.cmd_ir), 64'd3);
        do_udr(38'h10_0000_0077, 2, 1'b1);
        chk("new_ir_after", 64'(cmd_if.cmd_ir), 64'd0);

        // Reset mid-queue
        cmd_if.cmd_ready = 1'b0;
        do_udr(38'h11_1111_1111, 2, 1'b0);
        do_udr(38'h02_2222_2222, 2, 1'b0);
        chk("pre_rst_level", 64'(fifo_level), 64'd2);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_level", 64'(fifo_level), 64'd0);
        chk("mid_rst_jdo", 64'(cmd_if.jdo), 64'd0);
        chk("mid_rst_cmd_ir", 64'(cmd_if.cmd_ir), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        base = pulse_cnt;
        cmd_if.cmd_ready = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        chk("post_rst_no_pulse", 64'(pulse_cnt), 64'(base));
        chk("post_rst_level", 64'(fifo_level), 64'd0);
        chk("final_q_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
